// File: rtl/dmx_level_store_pkg.sv
// Shared constants, FSM encodings and the queued-command record for the DMX
// level store.
package dmx_level_store_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int DMX_NUM_PORTS = 4;
    localparam int DMX_NUM_CH    = 512;
    localparam int DMX_PORT_W    = 2;
    localparam int DMX_IDX_W     = 9;
    localparam int DMX_ADDR_W    = 11;
    localparam int DMX_CH_W      = 10;
    localparam int DMX_LEVEL_W   = 8;
    localparam int DMX_COUNT_W   = 16;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // Queued DIM command; ch_idx is the 0-based channel (channel - 1).
    typedef struct packed {
        logic [DMX_PORT_W-1:0]  port;
        logic [DMX_CH_W-1:0]    ch_idx;
        logic [DMX_LEVEL_W-1:0] level;
    } dmx_cmd_t;

endpackage

// File: rtl/dmx_level_store_if.sv
// Command, clear and read-port signals of the DMX level store, grouped so the
// parser side and the transmitter side see one bundle.
interface dmx_level_store_if;
    import dmx_level_store_pkg::*;

    logic                    cmd_valid;
    logic [DMX_PORT_W-1:0]   cmd_port;
    logic [DMX_CH_W-1:0]     cmd_channel;
    logic [DMX_LEVEL_W-1:0]  cmd_level;
    logic                    clear_req;
    logic [DMX_PORT_W-1:0]   rd_port;
    logic [DMX_IDX_W-1:0]    rd_addr;
    logic                    rd_en;
    logic [DMX_LEVEL_W-1:0]  rd_data;
    logic                    rd_valid;
    logic                    busy;
    logic                    cmd_overflow;
    logic                    cmd_err_addr;
    logic [DMX_COUNT_W-1:0]  wr_count;

    modport master (
        output cmd_valid, cmd_port, cmd_channel, cmd_level, clear_req,
        output rd_port, rd_addr, rd_en,
        input  rd_data, rd_valid, busy, cmd_overflow, cmd_err_addr, wr_count
    );

    modport slave (
        input  cmd_valid, cmd_port, cmd_channel, cmd_level, clear_req,
        input  rd_port, rd_addr, rd_en,
        output rd_data, rd_valid, busy, cmd_overflow, cmd_err_addr, wr_count
    );

endinterface

// File: rtl/dmx_cmd_fifo.sv
// Small synchronous command queue. A flush empties it; a push in the same
// cycle lands in the freshly emptied queue.
module dmx_cmd_fifo
    import dmx_level_store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  logic     flush,
    input  dmx_cmd_t din,
    output dmx_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    dmx_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && (flush || !full);
    assign do_pop  = pop && !empty && !flush;
    assign wr_idx  = flush ? '0 : wr_ptr;

    // Head is taken straight from the storage flops, so it is valid the
    // cycle after the push that filled an empty queue.
    assign head = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PTR_W'(1) : '0;
            count  <= do_push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers say which
    // entries are meaningful, and reset-free arrays map onto plain RAM/LUTs.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/dmx_level_store.sv
// Level memory for four DMX universes: queues DIM commands, writes them into a
// 2048x8 dual-port RAM, and zeroes the RAM with a sweep after reset or clear.
module dmx_level_store
    import dmx_level_store_pkg::*;
#(
    parameter int NUM_PORTS      = DMX_NUM_PORTS,
    parameter int NUM_CH         = DMX_NUM_CH,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    dmx_level_store_if.slave  bus
);

    localparam int MEM_DEPTH = NUM_PORTS * NUM_CH;
    localparam logic [DMX_ADDR_W-1:0] LAST_ADDR = DMX_ADDR_W'(MEM_DEPTH - 1);
    localparam logic [DMX_CH_W-1:0]   MAX_CH    = DMX_CH_W'(NUM_CH);

    logic [0:0]             state;
    logic [DMX_ADDR_W-1:0]  sweep_addr;

    logic                   addr_ok;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   overflow;
    dmx_cmd_t               push_cmd;
    dmx_cmd_t               head;
    logic                   unused_ch_msb;

    logic                   we;
    logic [DMX_ADDR_W-1:0]  waddr;
    logic [DMX_LEVEL_W-1:0] wdata;
    logic [DMX_ADDR_W-1:0]  raddr;

    logic [DMX_LEVEL_W-1:0] mem [MEM_DEPTH];
    logic [DMX_LEVEL_W-1:0] rd_data_q;
    logic                   rd_valid_q;
    logic                   overflow_q;
    logic                   err_addr_q;
    logic [DMX_COUNT_W-1:0] wr_count_q;

    // Range check on entry keeps bad addresses out of the queue entirely.
    assign addr_ok  = (bus.cmd_channel != '0) && (bus.cmd_channel <= MAX_CH);
    assign push_cmd = '{port:   bus.cmd_port,
                        ch_idx: bus.cmd_channel - DMX_CH_W'(1),
                        level:  bus.cmd_level};

    // A clear flushes first, so a simultaneous command always finds room.
    assign fifo_push = bus.cmd_valid && addr_ok && (bus.clear_req || !fifo_full);
    assign overflow  = bus.cmd_valid && addr_ok && fifo_full && !bus.clear_req;
    assign fifo_pop  = (state == S_RUN) && !fifo_empty && !bus.clear_req;

    dmx_cmd_fifo #(
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (bus.clear_req),
        .din   (push_cmd),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Queued indices are always below NUM_CH, so the top channel bit is zero.
    assign unused_ch_msb = head.ch_idx[DMX_CH_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            sweep_addr <= '0;
        end else if (bus.clear_req) begin
            state      <= S_CLEAR;
            sweep_addr <= '0;
        end else if (state == S_CLEAR) begin
            sweep_addr <= sweep_addr + DMX_ADDR_W'(1);
            if (sweep_addr == LAST_ADDR) state <= S_RUN;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = sweep_addr;
        wdata = '0;
        if (!bus.clear_req) begin
            if (state == S_CLEAR) begin
                we = 1'b1;
            end else if (fifo_pop) begin
                we    = 1'b1;
                waddr = {head.port, head.ch_idx[DMX_IDX_W-1:0]};
                wdata = head.level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign raddr = {bus.rd_port, bus.rd_addr};

    // Read and write share an edge, so a same-address read returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            err_addr_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            overflow_q <= overflow;
            err_addr_q <= bus.cmd_valid && !addr_ok;
            if (fifo_pop && (wr_count_q != '1)) wr_count_q <= wr_count_q + DMX_COUNT_W'(1);
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.busy         = (state == S_CLEAR);
    assign bus.cmd_overflow = overflow_q;
    assign bus.cmd_err_addr = err_addr_q;
    assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_dmx_level_store.sv
// Self-checking bench for dmx_level_store: directed table and corner-case
// sequences plus random traffic, all checked against a queue/array model.
module tb_dmx_level_store;
    import dmx_level_store_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmx_level_store_if bus ();

    dmx_level_store #(
        .NUM_PORTS      (4),
        .NUM_CH         (512),
        .CMD_FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         addr;
        logic [7:0] level;
    } ref_cmd_t;

    typedef struct {
        int         port;
        int         channel;
        logic [7:0] level;
        logic       err;
    } vec_t;

    // Behavioural reference: flat level array, command queue, sweep position.
    logic [7:0] ref_mem [2048];
    ref_cmd_t   ref_q [$];
    bit         ref_clearing;
    int         ref_sweep;
    int         ref_wr_count;
    logic [7:0] exp_rd_data;
    logic       exp_rd_valid;
    logic       exp_ovf;
    logic       exp_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        ref_clearing = 1'b1;
        ref_sweep    = 0;
        ref_wr_count = 0;
        exp_rd_data  = 8'h00;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_err      = 1'b0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit       ok;
        bit       was_full;
        ref_cmd_t e;
        int       ch;
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_rd_valid = bus.rd_en;
        if (bus.rd_en) exp_rd_data = ref_mem[int'(bus.rd_port) * 512 + int'(bus.rd_addr)];
        ch       = int'(bus.cmd_channel);
        ok       = bus.cmd_valid && ch >= 1 && ch <= 512;
        exp_err  = bus.cmd_valid && !ok;
        was_full = (ref_q.size() == 4);
        if (bus.clear_req) begin
            ref_q.delete();
            ref_clearing = 1'b1;
            ref_sweep    = 0;
        end else if (ref_clearing) begin
            ref_mem[ref_sweep] = 8'h00;
            ref_sweep++;
            if (ref_sweep == 2048) ref_clearing = 1'b0;
        end else if (ref_q.size() > 0) begin
            e = ref_q.pop_front();
            ref_mem[e.addr] = e.level;
            if (ref_wr_count < 65535) ref_wr_count++;
        end
        exp_ovf = 1'b0;
        if (ok) begin
            if (bus.clear_req || !was_full) begin
                e.addr  = int'(bus.cmd_port) * 512 + ch - 1;
                e.level = bus.cmd_level;
                ref_q.push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("busy", bus.busy, ref_clearing);
        check("rd_valid", bus.rd_valid, exp_rd_valid);
        check("rd_data", bus.rd_data, exp_rd_data);
        check("cmd_overflow", bus.cmd_overflow, exp_ovf);
        check("cmd_err_addr", bus.cmd_err_addr, exp_err);
        check("wr_count", bus.wr_count, ref_wr_count);
    endtask

    task automatic set_idle();
        bus.cmd_valid   = 1'b0;
        bus.cmd_port    = '0;
        bus.cmd_channel = '0;
        bus.cmd_level   = '0;
        bus.clear_req   = 1'b0;
        bus.rd_en       = 1'b0;
        bus.rd_port     = '0;
        bus.rd_addr     = '0;
    endtask

    task automatic send_cmd(input int port, input int channel, input logic [7:0] level);
        bus.cmd_valid   = 1'b1;
        bus.cmd_port    = 2'(port);
        bus.cmd_channel = 10'(channel);
        bus.cmd_level   = level;
        cycle();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic do_read(input string name, input int port, input int addr, input logic [7:0] expected);
        bus.rd_en   = 1'b1;
        bus.rd_port = 2'(port);
        bus.rd_addr = 9'(addr);
        cycle();
        bus.rd_en   = 1'b0;
        check(name, bus.rd_data, expected);
        check({name, "_valid"}, bus.rd_valid, 1);
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (bus.busy && n < limit) begin
            cycle();
            n++;
        end
        check("busy_timeout", bus.busy, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   n;

        set_idle();
        model_reset();

        // Reset values and the post-reset sweep length.
        idle_cycles(3);
        check("rst_busy", bus.busy, 1);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        rst_n = 1'b1;
        wait_idle(3000, n);
        check("sweep_len", n, 2048);
        do_read("t1_p0a0", 0, 0, 8'h00);
        do_read("t1_p3a511", 3, 511, 8'h00);

        // Write latency: cmd at T, read in T+2, data visible after.
        send_cmd(2, 1, 8'h80);
        cycle();
        do_read("t2_p2a0", 2, 0, 8'h80);
        check("t2_wr_count", bus.wr_count, 1);

        // Table: edge channels and rejected addresses.
        vecs = '{'{3, 512, 8'hFF, 1'b0},
                 '{0, 0,   8'h12, 1'b1},
                 '{1, 513, 8'h34, 1'b1},
                 '{2, 300, 8'h5A, 1'b0},
                 '{0, 1,   8'hC3, 1'b0},
                 '{1, 1023, 8'h77, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].port, vecs[i].channel, vecs[i].level);
            check($sformatf("t3_err_%0d", i), bus.cmd_err_addr, vecs[i].err);
        end
        idle_cycles(3);
        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].err) do_read($sformatf("t3_rd_%0d", i), vecs[i].port, vecs[i].channel - 1, vecs[i].level);
        end
        do_read("t3_p1a0_untouched", 1, 0, 8'h00);
        do_read("t3_p2a0_untouched", 2, 0, 8'h80);

        // Overflow while the FIFO is stalled by a clear sweep.
        bus.clear_req = 1'b1;
        cycle();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_cmd(0, 100 + i, 8'(8'h10 + i));
            check($sformatf("t4_ovf_%0d", i), bus.cmd_overflow, (i == 4));
        end
        wait_idle(2100, n);
        idle_cycles(6);
        for (int i = 0; i < 4; i++) do_read($sformatf("t4_rd_%0d", i), 0, 99 + i, 8'(8'h10 + i));
        do_read("t4_dropped", 0, 103, 8'h00);
        do_read("t4_cleared", 2, 0, 8'h00);

        // Clear and command in the same cycle.
        send_cmd(1, 10, 8'h55);
        idle_cycles(2);
        do_read("t5_pre", 1, 9, 8'h55);
        bus.clear_req = 1'b1;
        send_cmd(0, 5, 8'h22);
        bus.clear_req = 1'b0;
        wait_idle(2100, n);
        idle_cycles(3);
        do_read("t5_p1a9", 1, 9, 8'h00);
        do_read("t5_p0a4", 0, 4, 8'h22);

        // Back-to-back writes and read-during-write returning old data.
        send_cmd(0, 7, 8'h11);
        send_cmd(0, 7, 8'h99);
        do_read("t6_rdw_old", 0, 6, 8'h11);
        do_read("t6_new", 0, 6, 8'h99);
        check("t6_wr_count", bus.wr_count, 12);

        // Reset in the middle of a sweep restarts the full sweep.
        bus.clear_req = 1'b1;
        cycle();
        bus.clear_req = 1'b0;
        idle_cycles(100);
        rst_n = 1'b0;
        cycle();
        check("t6_rst_busy", bus.busy, 1);
        check("t6_rst_wr_count", bus.wr_count, 0);
        rst_n = 1'b1;
        wait_idle(3000, n);
        check("t6_sweep_len", n, 2048);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_port  = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 19));
            if (r == 0)      bus.cmd_channel = 10'd0;
            else if (r == 1) bus.cmd_channel = 10'($urandom_range(513, 1023));
            else if (r < 12) bus.cmd_channel = 10'($urandom_range(1, 16));
            else             bus.cmd_channel = 10'($urandom_range(1, 512));
            bus.cmd_level = 8'($urandom_range(0, 255));
            bus.clear_req = ($urandom_range(0, 599) == 0);
            bus.rd_en     = 1'($urandom_range(0, 1));
            bus.rd_port   = 2'($urandom_range(0, 3));
            bus.rd_addr   = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
            cycle();
        end
        set_idle();
        idle_cycles(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
